// File: rtl/bcd_down_counter_99_0_pkg.sv
// Shared constants and BCD helpers for the two-digit BCD counters.
// Pure definitions: no state, no timing, no handshakes.
package bcd_down_counter_99_0_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BIN_W   = 7;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // tens*10 + ones built from shifts so no multiplier is inferred
  function automatic logic [BIN_W-1:0] bcd2bin(input logic [DIGIT_W-1:0] tens,
                                               input logic [DIGIT_W-1:0] ones);
    logic [BIN_W-1:0] t;
    logic [BIN_W-1:0] o;
    t = BIN_W'(tens);
    o = BIN_W'(ones);
    return (t << 3) + (t << 1) + o;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrementer: 0 wraps to 9 and raises borrow_out.
// Purely combinational, zero latency; no flow control.
module bcd_digit_dec
  import bcd_down_counter_99_0_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_dat,
  input  logic               dec_req,
  output logic [DIGIT_W-1:0] next_dat,
  output logic               borrow_out
);

  always_comb begin
    next_dat   = digit_dat;
    borrow_out = 1'b0;
    if (dec_req) begin
      if (digit_dat == '0) begin
        next_dat   = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        next_dat = digit_dat - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_counter_99_0.sv
// Two-digit BCD down-counter 99..00 with load, prescaler, wrap/hold and binary mirror.
// All outputs registered, one edge after load/tick; en only stalls the prescaler, no backpressure.
module bcd_down_counter_99_0
  import bcd_down_counter_99_0_pkg::*;
#(
  parameter int unsigned RESET_TENS = 9,
  parameter int unsigned RESET_ONES = 9,
  parameter bit          WRAP       = 1'b1,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_tens,
  input  logic [DIGIT_W-1:0] load_ones,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic [BIN_W-1:0]   value_bin,
  output logic               zero,
  output logic               borrow,
  output logic               load_err
);

  localparam logic [DIGIT_W-1:0] RST_TENS  = 4'(RESET_TENS);
  localparam logic [DIGIT_W-1:0] RST_ONES  = 4'(RESET_ONES);
  localparam logic [BIN_W-1:0]   RST_BIN   = bcd2bin(RST_TENS, RST_ONES);
  localparam logic               RST_ZERO  = (RESET_TENS == 0) && (RESET_ONES == 0);
  localparam logic [7:0]         TICK_LAST = 8'(TICK_DIV - 1);

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               zero_q, zero_d;
  logic               borrow_q, borrow_d;
  logic               load_err_q, load_err_d;
  logic [7:0]         presc_q, presc_d;

  logic               tick;
  logic               load_ok;
  logic               digits_bad;
  logic [DIGIT_W-1:0] ones_nxt, tens_nxt;
  logic               ones_bo, tens_bo;

  assign tick       = en && (presc_q == TICK_LAST);
  assign load_ok    = (load_tens <= BCD_MAX) && (load_ones <= BCD_MAX);
  assign digits_bad = (tens_q > BCD_MAX) || (ones_q > BCD_MAX);

  bcd_digit_dec u_ones_dec (
    .digit_dat  (ones_q),
    .dec_req    (tick),
    .next_dat   (ones_nxt),
    .borrow_out (ones_bo)
  );

  // tens only moves when the ones digit rolls 0 -> 9
  bcd_digit_dec u_tens_dec (
    .digit_dat  (tens_q),
    .dec_req    (ones_bo),
    .next_dat   (tens_nxt),
    .borrow_out (tens_bo)
  );

  always_comb begin
    tens_d     = tens_q;
    ones_d     = ones_q;
    presc_d    = presc_q;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        tens_d  = load_tens;
        ones_d  = load_ones;
        presc_d = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick) begin
      presc_d = '0;
      if (digits_bad) begin
        tens_d = BCD_MAX;
        ones_d = BCD_MAX;
      end else begin
        tens_d   = tens_nxt;
        ones_d   = ones_nxt;
        borrow_d = tens_bo;
        // tens borrow means the count was 00; without wrap it sticks there
        if (tens_bo && !WRAP) begin
          tens_d = '0;
          ones_d = '0;
        end
      end
    end else if (en) begin
      presc_d = presc_q + 8'd1;
    end
    bin_d  = bcd2bin(tens_d, ones_d);
    zero_d = (tens_d == '0) && (ones_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q     <= RST_TENS;
      ones_q     <= RST_ONES;
      bin_q      <= RST_BIN;
      zero_q     <= RST_ZERO;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
      presc_q    <= '0;
    end else begin
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      bin_q      <= bin_d;
      zero_q     <= zero_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
      presc_q    <= presc_d;
    end
  end

  assign tens      = tens_q;
  assign ones      = ones_q;
  assign value_bin = bin_q;
  assign zero      = zero_q;
  assign borrow    = borrow_q;
  assign load_err  = load_err_q;

endmodule
